// File: rtl/spi_master.sv
// SPI bus initiator: one DATA_WIDTH-bit full-duplex frame per start strobe, SPI modes 0-3.
// Define SPI_LSB_FIRST_EN to shift LSB first in both directions (default MSB first).
module spi_master #(
  parameter int SPI_MODE   = 0,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_TX_start,
  input  logic [DATA_WIDTH-1:0] i_TX_data,
  output logic                  o_TX_ready,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  input  logic                  i_miso,
  output logic [DATA_WIDTH-1:0] o_RX_data,
  output logic                  o_RX_done
);

  // state    | meaning
  // IDLE     | waiting for a start, cs_n high
  // SETUP    | cs_n dropped, first bit presented for CPHA=0
  // TRANSFER | 2*DATA_WIDTH SCLK toggles
  // HOLD     | last half-period before cs_n rises
  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   EW   = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CW-1:0] HP_LAST   = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH);

  state_t state, state_next;
  logic [CW-1:0] hp_cnt;
  logic [EW-1:0] edge_cnt, edge_num;
  logic [DATA_WIDTH-1:0] tx_reg, rx_reg, tx_shifted, rx_shifted;
  logic tx_bit, hp_last, setup_entry;
  logic accept, toggle, finish, sample, drive;

  assign hp_last     = (hp_cnt == HP_LAST);
  assign edge_num    = edge_cnt + EW'(1);
  assign setup_entry = (state == SETUP) && o_cs_n;

`ifdef SPI_LSB_FIRST_EN
  assign tx_bit     = tx_reg[0];
  assign tx_shifted = tx_reg >> 1;
  assign rx_shifted = {i_miso, rx_reg[DATA_WIDTH-1:1]};
`else
  assign tx_bit     = tx_reg[DATA_WIDTH-1];
  assign tx_shifted = tx_reg << 1;
  assign rx_shifted = {rx_reg[DATA_WIDTH-2:0], i_miso};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_TX_ready = 1'b0;
    accept     = 1'b0;
    toggle     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        o_TX_ready = 1'b1;
        if (i_TX_start) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (!o_cs_n && hp_last) begin
          toggle     = 1'b1;
          state_next = TRANSFER;
        end
      end
      TRANSFER: begin
        if (hp_last) begin
          toggle = 1'b1;
          if (edge_num == EDGE_LAST) state_next = HOLD;
        end
      end
      HOLD: begin
        // Ready rises in the final HOLD cycle so a start here chains frames with one idle cs_n cycle.
        if (hp_last) begin
          o_TX_ready = 1'b1;
          finish     = 1'b1;
          if (i_TX_start) begin
            accept     = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    sample = toggle && (CPHA ? !edge_num[0] : edge_num[0]);
    drive  = toggle && (CPHA ? edge_num[0] : (!edge_num[0] && (edge_num != EDGE_LAST)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_sclk    <= CPOL;
      o_cs_n    <= 1'b1;
      o_mosi    <= 1'b0;
      o_RX_data <= '0;
      o_RX_done <= 1'b0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      hp_cnt    <= '0;
      edge_cnt  <= '0;
    end else begin
      o_RX_done <= finish;
      if (finish) begin
        o_cs_n    <= 1'b1;
        o_RX_data <= rx_reg;
      end
      if (setup_entry) begin
        o_cs_n <= 1'b0;
        hp_cnt <= '0;
        if (!CPHA) begin
          o_mosi <= tx_bit;
          tx_reg <= tx_shifted;
        end
      end else if (state != IDLE) begin
        hp_cnt <= hp_last ? '0 : hp_cnt + CW'(1);
      end
      if (toggle) begin
        o_sclk   <= ~o_sclk;
        edge_cnt <= edge_num;
      end
      if (sample) rx_reg <= rx_shifted;
      if (drive) begin
        o_mosi <= tx_bit;
        tx_reg <= tx_shifted;
      end
      if (accept) begin
        tx_reg   <= i_TX_data;
        rx_reg   <= '0;
        hp_cnt   <= '0;
        edge_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: five instances (modes 0-3 at CLK_DIV=2, mode 0 at CLK_DIV=1)
// against a behavioural SPI slave / loopback model with a per-instance expectation queue.
module tb_spi_master;
  localparam int N = 5;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst[N], start[N], ready[N], sclk[N], mosi[N], cs_n[N], miso[N], done[N];
  logic loop_en[N], s_miso[N];
  logic [W-1:0] txd[N], rxd[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_master #(
      .SPI_MODE  (g < 4 ? g : 0),
      .DATA_WIDTH(W),
      .CLK_DIV   (g < 4 ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .i_TX_start(start[g]),
      .i_TX_data (txd[g]),
      .o_TX_ready(ready[g]),
      .o_sclk    (sclk[g]),
      .o_mosi    (mosi[g]),
      .o_cs_n    (cs_n[g]),
      .i_miso    (miso[g]),
      .o_RX_data (rxd[g]),
      .o_RX_done (done[g])
    );
    assign miso[g] = loop_en[g] ? mosi[g] : s_miso[g];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mode_of(input int g); return (g < 4) ? g : 0; endfunction
  function automatic logic cpol_of(input int g); return mode_of(g) >= 2; endfunction
  function automatic logic cpha_of(input int g); return (mode_of(g) % 2) == 1; endfunction
  function automatic int div_of(input int g); return (g < 4) ? 2 : 1; endfunction
  function automatic int bitpos(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  // slave/monitor model state, touched only by the main process
  logic prev_cs[N], prev_sclk[N];
  int edges[N], toggles[N], low_cnt[N], hi_cnt[N], gap[N], n_out[N], n_in[N], done_total[N];
  logic [W-1:0] s_word_next[N], s_cap[N], s_rx[N];
  logic [W-1:0] exp_q[N][$];

  task automatic frame_end(input int g);
    logic [W-1:0] m;
    done_total[g]++;
    check($sformatf("done_expected[%0d]", g), exp_q[g].size() > 0, 1);
    if (exp_q[g].size() > 0) begin
      m = exp_q[g].pop_front();
      check($sformatf("rx_data[%0d]", g), rxd[g], loop_en[g] ? m : s_cap[g]);
      if (!loop_en[g]) check($sformatf("slave_rx[%0d]", g), s_rx[g], m);
      check($sformatf("cs_low_cycles[%0d]", g), low_cnt[g], (2 * W + 1) * div_of(g));
      check($sformatf("sclk_toggles[%0d]", g), toggles[g], 2 * W);
      check($sformatf("cs_at_done[%0d]", g), cs_n[g], 1);
      check($sformatf("sclk_at_done[%0d]", g), sclk[g], cpol_of(g));
      check($sformatf("mosi_hold[%0d]", g), mosi[g], m[bitpos(W - 1)]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      if (prev_cs[g] && !cs_n[g]) begin
        gap[g] = hi_cnt[g];
        hi_cnt[g] = 0; edges[g] = 0; toggles[g] = 0; low_cnt[g] = 0;
        n_out[g] = 0; n_in[g] = 0;
        s_cap[g] = s_word_next[g];
        s_rx[g] = '0;
        if (!cpha_of(g)) begin
          s_miso[g] = s_cap[g][bitpos(0)];
          n_out[g] = 1;
        end
      end
      if (cs_n[g]) hi_cnt[g]++;
      else         low_cnt[g]++;
      if (sclk[g] !== prev_sclk[g]) begin
        toggles[g]++;
        if (!cs_n[g]) begin
          edges[g]++;
          if (((edges[g] % 2) == 1) != cpha_of(g)) begin
            if (n_in[g] < W) s_rx[g][bitpos(n_in[g])] = mosi[g];
            n_in[g]++;
          end else if (n_out[g] < W) begin
            s_miso[g] = s_cap[g][bitpos(n_out[g])];
            n_out[g]++;
          end
        end
      end
      if (done[g]) frame_end(g);
      prev_cs[g] = cs_n[g];
      prev_sclk[g] = sclk[g];
    end
  endtask

  task automatic start_frame(input int g, input logic [W-1:0] m, input logic [W-1:0] s);
    int t;
    t = 0;
    while (!ready[g] && t < 200) begin tick(); t++; end
    check($sformatf("ready_before_start[%0d]", g), ready[g], 1);
    s_word_next[g] = s;
    txd[g] = m;
    start[g] = 1'b1;
    exp_q[g].push_back(m);
    tick();
    start[g] = 1'b0;
    txd[g] = W'($urandom);
    check($sformatf("ready_after_start[%0d]", g), ready[g], 0);
  endtask

  task automatic wait_done(input int g);
    int d0, t;
    d0 = done_total[g];
    t = 0;
    while (done_total[g] == d0 && t < 1000) begin tick(); t++; end
    check($sformatf("frame_completed[%0d]", g), done_total[g] - d0, 1);
  endtask

  task automatic wait_edges(input int g, input int n);
    int t;
    t = 0;
    while (cs_n[g] && t < 200) begin tick(); t++; end
    while (edges[g] < n && t < 400) begin tick(); t++; end
    check($sformatf("reached_edge[%0d]", g), edges[g], n);
  endtask

  initial begin
    logic [W-1:0] m, s;
    int d_before;
    int t;
    for (int g = 0; g < N; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; txd[g] = '0; loop_en[g] = 1'b0; s_miso[g] = 1'b0;
      s_word_next[g] = '0; s_cap[g] = '0; s_rx[g] = '0;
      prev_cs[g] = 1'b1; prev_sclk[g] = cpol_of(g);
      edges[g] = 0; toggles[g] = 0; low_cnt[g] = 0; hi_cnt[g] = 0; gap[g] = 0;
      n_out[g] = 0; n_in[g] = 0; done_total[g] = 0;
    end
    repeat (3) tick();
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_cs_n[%0d]", g), cs_n[g], 1);
      check($sformatf("rst_sclk[%0d]", g), sclk[g], cpol_of(g));
      check($sformatf("rst_mosi[%0d]", g), mosi[g], 0);
      check($sformatf("rst_ready[%0d]", g), ready[g], 1);
      check($sformatf("rst_rx_data[%0d]", g), rxd[g], 0);
      check($sformatf("rst_done[%0d]", g), done[g], 0);
      rst[g] = 1'b0;
    end
    repeat (2) tick();

    // loopback, mode 0, 0xA5
    loop_en[0] = 1'b1;
    start_frame(0, 8'hA5, 8'h00);
    wait_done(0);
    loop_en[0] = 1'b0;
    repeat (3) tick();

    // every mode against the slave model: fixed pattern then random words
    for (int g = 0; g < 4; g++) begin
      start_frame(g, 8'h3C, 8'hC3);
      wait_done(g);
      repeat (2) tick();
      check($sformatf("idle_sclk[%0d]", g), sclk[g], cpol_of(g));
      for (int r = 0; r < 4; r++) begin
        m = W'($urandom);
        s = W'($urandom);
        start_frame(g, m, s);
        wait_done(g);
        repeat ($urandom_range(0, 3)) tick();
      end
    end

    // start while busy is ignored
    d_before = done_total[1];
    start_frame(1, W'($urandom), W'($urandom));
    wait_edges(1, 5);
    start[1] = 1'b1;
    txd[1] = 8'hFF;
    tick();
    start[1] = 1'b0;
    wait_done(1);
    repeat (12) tick();
    check("ignored_start_done_count", done_total[1] - d_before, 1);
    check("ignored_start_cs_idle", cs_n[1], 1);

    // reset mid-frame at toggle 7, then a clean frame
    d_before = done_total[2];
    start_frame(2, W'($urandom), W'($urandom));
    wait_edges(2, 7);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    check("midrst_cs_n", cs_n[2], 1);
    check("midrst_sclk", sclk[2], cpol_of(2));
    check("midrst_ready", ready[2], 1);
    check("midrst_done", done[2], 0);
    exp_q[2].delete();
    repeat (3) tick();
    check("midrst_no_done", done_total[2] - d_before, 0);
    start_frame(2, 8'h5A, W'($urandom));
    wait_done(2);

    // back-to-back at CLK_DIV=1, second start on the cycle ready rises
    loop_en[4] = 1'b1;
    start_frame(4, 8'h01, 8'h00);
    t = 0;
    while (!ready[4] && t < 200) begin tick(); t++; end
    check("b2b_ready_rose", ready[4], 1);
    d_before = done_total[4];
    s_word_next[4] = 8'h00;
    txd[4] = 8'h80;
    start[4] = 1'b1;
    exp_q[4].push_back(8'h80);
    tick();
    start[4] = 1'b0;
    check("b2b_first_done", done_total[4] - d_before, 1);
    wait_done(4);
    check("b2b_cs_gap", gap[4], 1);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
